computational_unit_p: RTL and testbench

Parametrised successor to the 4-bit computational unit. Holds the microcontroller's data registers (x0, x1, y0, y1, m, i, o_reg), the result registers and the status flags. Drives the internal data bus and executes ALU instructions decoded from the instruction nibble. New in this generation:
- configurable data width;
- a multi-cycle shift-add multiplier that writes a double-width product with a busy handshake;
- carry and negative flags;
- modulo index addressing for `i`.

---
 rtl/computational_unit_p.sv | 247 ++++++++++++++++++++++++
 tb/tb_computational_unit_p.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/computational_unit_p.sv
// computational_unit_p
//
// Datapath core of the microcontroller. It holds the data registers
// (x0, x1, y0, y1, m, i, o_reg), the result registers r/r_hi and the status
// flags. It drives the internal data bus and executes ALU instructions
// decoded from the instruction nibble. Multiply is an unsigned shift-add
// that takes WIDTH cycles and reports progress on 'busy'.
//
// Parameters:
//   WIDTH  data path width
//   I_MOD  modulus for index post-increment (2..2**WIDTH)
//
// Ports:
//   clk            system clock, rising edge
//   async_reset_n  asynchronous active-low reset
//   source_sel     data bus source select (0..10, others drive 0)
//   nibble_ir      ALU instruction: [2:0] opcode, [3] NOP qualifier
//   pm_data        immediate operand from program memory
//   i_pins         input pins
//   dm             data memory read data
//   x_sel, y_sel   ALU operand selects (x0/x1, y0/y1)
//   i_sel          index load mode: 0 bus load, 1 modulo post-increment
//   reg_en         write enables: x0,x1,y0,y1,ALU issue,m,i,-,o_reg
//   data_bus       combinational bus value
//   o_reg, i       output and index registers
//   r, r_hi        result register and high half of last product
//   zero_flag, carry_flag, neg_flag   status flags
//   busy           multiplier in progress
module computational_unit_p #(
  parameter int WIDTH = 4,
  parameter int I_MOD = 2**WIDTH
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic [3:0]       source_sel,
  input  logic [3:0]       nibble_ir,
  input  logic [WIDTH-1:0] pm_data,
  input  logic [WIDTH-1:0] i_pins,
  input  logic [WIDTH-1:0] dm,
  input  logic             x_sel,
  input  logic             y_sel,
  input  logic             i_sel,
  input  logic [8:0]       reg_en,
  output logic [WIDTH-1:0] data_bus,
  output logic [WIDTH-1:0] o_reg,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] MOD = (WIDTH + 1)'(I_MOD);

  typedef enum logic [0:0] {IDLE = 1'b0, MULT = 1'b1} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   x0, x1, y0, y1, m;
  logic [WIDTH-1:0]   x_op, y_op;
  logic [2:0]         opcode;
  logic               issue, start_mul, mul_done;

  logic [WIDTH-1:0]   alu_r;
  logic               alu_carry, alu_wr;
  logic [WIDTH:0]     alu_sum;

  logic [WIDTH:0]     idx_sum, idx_next;

  // Multiplier state: acc holds {partial product high, remaining multiplier}
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc, mul_next;
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH:0]   mul_cat;
  logic [CW-1:0]      cnt;

  // reg_en[7] has no register behind it; the top bit of idx_next and the bit
  // shifted out of mul_cat are never needed.
  logic [2:0]         unused_bits;
  assign unused_bits = {reg_en[7], idx_next[WIDTH], mul_cat[0]};

  assign x_op      = x_sel ? x1 : x0;
  assign y_op      = y_sel ? y1 : y0;
  assign opcode    = nibble_ir[2:0];
  // Issue while the multiplier runs is dropped, not queued.
  assign issue     = reg_en[4] && !busy;
  assign start_mul = issue && (opcode == 3'd3);
  assign mul_done  = (state == MULT) && (cnt == CW'(1));

  // Data bus source multiplexer
  always_comb begin
    data_bus = '0;
    case (source_sel)
      4'd0:    data_bus = x0;
      4'd1:    data_bus = x1;
      4'd2:    data_bus = y0;
      4'd3:    data_bus = y1;
      4'd4:    data_bus = r;
      4'd5:    data_bus = m;
      4'd6:    data_bus = i;
      4'd7:    data_bus = dm;
      4'd8:    data_bus = pm_data;
      4'd9:    data_bus = i_pins;
      4'd10:   data_bus = r_hi;
      default: data_bus = '0;
    endcase
  end

  // Modulo post-increment; i and m are both below I_MOD so one subtraction
  // brings the sum back into range.
  always_comb begin
    idx_sum  = {1'b0, i} + {1'b0, m};
    idx_next = (idx_sum >= MOD) ? (idx_sum - MOD) : idx_sum;
  end

  // Single-cycle ALU; alu_wr is low for multiply and for qualified NOPs
  always_comb begin
    alu_r     = '0;
    alu_carry = 1'b0;
    alu_wr    = 1'b0;
    alu_sum   = '0;
    case (opcode)
      3'd0: begin
        if (!nibble_ir[3]) begin
          alu_r     = -x_op;
          alu_carry = (x_op != '0);
          alu_wr    = 1'b1;
        end
      end
      3'd1: begin
        alu_sum   = {1'b0, x_op} - {1'b0, y_op};
        alu_r     = alu_sum[WIDTH-1:0];
        alu_carry = alu_sum[WIDTH];
        alu_wr    = 1'b1;
      end
      3'd2: begin
        alu_sum   = {1'b0, x_op} + {1'b0, y_op};
        alu_r     = alu_sum[WIDTH-1:0];
        alu_carry = alu_sum[WIDTH];
        alu_wr    = 1'b1;
      end
      3'd4: begin
        alu_r     = x_op << 1;
        alu_carry = x_op[WIDTH-1];
        alu_wr    = 1'b1;
      end
      3'd5: begin
        alu_r  = x_op ^ y_op;
        alu_wr = 1'b1;
      end
      3'd6: begin
        alu_r  = x_op & y_op;
        alu_wr = 1'b1;
      end
      3'd7: begin
        if (!nibble_ir[3]) begin
          alu_r  = ~x_op;
          alu_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  always_comb begin
    mul_add  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_cat  = {mul_add, acc[WIDTH-1:0]};
    mul_next = mul_cat[2*WIDTH:1];
  end

  // Multiplier FSM state register
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) state <= IDLE;
    else                state <= state_next;
  end

  // Multiplier FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_mul) state_next = MULT;
      MULT:    if (mul_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiplier FSM outputs
  always_comb begin
    busy = (state == MULT);
  end

  // Register file, result registers and flags
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      x0         <= '0;
      x1         <= '0;
      y0         <= '0;
      y1         <= '0;
      m          <= '0;
      i          <= '0;
      o_reg      <= '0;
      r          <= '0;
      r_hi       <= '0;
      zero_flag  <= 1'b1;
      carry_flag <= 1'b0;
      neg_flag   <= 1'b0;
      mcand      <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      if (reg_en[0]) x0    <= data_bus;
      if (reg_en[1]) x1    <= data_bus;
      if (reg_en[2]) y0    <= data_bus;
      if (reg_en[3]) y1    <= data_bus;
      if (reg_en[5]) m     <= data_bus;
      if (reg_en[8]) o_reg <= data_bus;
      if (reg_en[6]) i     <= i_sel ? idx_next[WIDTH-1:0] : data_bus;

      if (start_mul) begin
        mcand <= x_op;
        acc   <= {{WIDTH{1'b0}}, y_op};
        cnt   <= CW'(WIDTH);
      end else if (state == MULT) begin
        acc <= mul_next;
        cnt <= cnt - CW'(1);
        if (mul_done) begin
          r          <= mul_next[WIDTH-1:0];
          r_hi       <= mul_next[2*WIDTH-1:WIDTH];
          zero_flag  <= (mul_next == '0);
          carry_flag <= (mul_next[2*WIDTH-1:WIDTH] != '0);
          neg_flag   <= mul_next[2*WIDTH-1];
        end
      end else if (issue && alu_wr) begin
        r          <= alu_r;
        zero_flag  <= (alu_r == '0);
        carry_flag <= alu_carry;
        neg_flag   <= alu_r[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_computational_unit_p.sv
// tb_computational_unit_p
//
// Self-checking bench for computational_unit_p with WIDTH = 4, I_MOD = 12.
// A reference model of the architectural state (plain integers) is advanced
// alongside the stimulus; DUT outputs are sampled 1 ns after each rising edge.
module tb_computational_unit_p;

  localparam int W    = 4;
  localparam int IMOD = 12;
  localparam int FULL = 16;

  logic       clk = 1'b0;
  logic       async_reset_n;
  logic [3:0] source_sel, nibble_ir;
  logic [3:0] pm_data, i_pins, dm;
  logic       x_sel, y_sel, i_sel;
  logic [8:0] reg_en;
  logic [3:0] data_bus, o_reg, i, r, r_hi;
  logic       zero_flag, carry_flag, neg_flag, busy;

  always #5 clk = ~clk;

  computational_unit_p #(.WIDTH(W), .I_MOD(IMOD)) dut (
    .clk(clk), .async_reset_n(async_reset_n), .source_sel(source_sel),
    .nibble_ir(nibble_ir), .pm_data(pm_data), .i_pins(i_pins), .dm(dm),
    .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel), .reg_en(reg_en),
    .data_bus(data_bus), .o_reg(o_reg), .i(i), .r(r), .r_hi(r_hi),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .neg_flag(neg_flag),
    .busy(busy)
  );

  logic [11:0] status;
  assign status = {r, r_hi, zero_flag, carry_flag, neg_flag, busy};

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int m_x[2], m_y[2];
  int m_m, m_i, m_o, m_r, m_rhi, m_z, m_c, m_n;

  function automatic logic [11:0] exp_status(input bit b);
    return {4'(m_r), 4'(m_rhi), 1'(m_z), 1'(m_c), 1'(m_n), b};
  endfunction

  function automatic int bus_model(input int sel);
    case (sel)
      0: return m_x[0];
      1: return m_x[1];
      2: return m_y[0];
      3: return m_y[1];
      4: return m_r;
      5: return m_m;
      6: return m_i;
      7: return int'(dm);
      8: return int'(pm_data);
      9: return int'(i_pins);
      10: return m_rhi;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_x[0] = 0; m_x[1] = 0; m_y[0] = 0; m_y[1] = 0;
    m_m = 0; m_i = 0; m_o = 0; m_r = 0; m_rhi = 0;
    m_z = 1; m_c = 0; m_n = 0;
  endtask

  task automatic model_single(input int op, input bit nop, input int x, input int y);
    int res;
    bit wr;
    res = 0;
    wr  = 1'b1;
    case (op)
      0: if (nop) wr = 1'b0; else begin res = (FULL - x) % FULL; m_c = (x != 0); end
      1: begin res = (x - y + FULL) % FULL; m_c = (x < y); end
      2: begin res = (x + y) % FULL; m_c = ((x + y) >= FULL); end
      4: begin res = (x * 2) % FULL; m_c = (x >= FULL / 2); end
      5: begin res = x ^ y; m_c = 0; end
      6: begin res = x & y; m_c = 0; end
      7: if (nop) wr = 1'b0; else begin res = FULL - 1 - x; m_c = 0; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_r = res;
      m_z = (res == 0);
      m_n = (res >= FULL / 2);
    end
  endtask

  task automatic model_mul(input int x, input int y);
    int p;
    p     = x * y;
    m_r   = p % FULL;
    m_rhi = p / FULL;
    m_z   = (p == 0);
    m_c   = (p >= FULL);
    m_n   = (m_rhi >= FULL / 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a register from pm_data through the bus: 0 x0, 1 x1, 2 y0, 3 y1, 5 m, 6 i, 8 o_reg
  task automatic load(input int which, input int val);
    source_sel = 4'd8;
    pm_data    = 4'(val);
    i_sel      = 1'b0;
    reg_en     = 9'(1 << which);
    tick();
    reg_en = '0;
    case (which)
      0: m_x[0] = val;
      1: m_x[1] = val;
      2: m_y[0] = val;
      3: m_y[1] = val;
      5: m_m = val;
      6: m_i = val;
      8: m_o = val;
      default: ;
    endcase
  endtask

  task automatic issue_single(input int op, input bit nop, input bit xs, input bit ys);
    nibble_ir = {nop, 3'(op)};
    x_sel     = xs;
    y_sel     = ys;
    reg_en    = 9'h010;
    tick();
    reg_en = '0;
    model_single(op, nop, m_x[xs], m_y[ys]);
  endtask

  task automatic issue_mul(input bit xs, input bit ys);
    nibble_ir = 4'h3;
    x_sel     = xs;
    y_sel     = ys;
    reg_en    = 9'h010;
    tick();
    reg_en = '0;
  endtask

  task automatic test_reset();
    async_reset_n = 1'b0;
    #7;
    async_reset_n = 1'b1;
    model_reset();
    source_sel = 4'd4;
    #1;
    compared++;
    if (data_bus !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: got %h expected 0", data_bus);
    end
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL reset_status: got %h expected %h", status, exp_status(1'b0));
    end
    compared++;
    if ({i, o_reg} !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_i_o: got %h expected 00", {i, o_reg});
    end
  endtask

  task automatic test_add_sub();
    load(0, 9);
    load(2, 8);
    issue_single(2, 1'b0, 1'b0, 1'b0);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL add_9_8: got %h expected %h", status, exp_status(1'b0));
    end
    load(0, 3);
    load(2, 5);
    issue_single(1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL sub_3_5: got %h expected %h", status, exp_status(1'b0));
    end
  endtask

  task automatic test_multiply();
    load(1, 7);
    load(3, 9);
    issue_mul(1'b1, 1'b1);
    for (int k = 0; k < W; k++) begin
      compared++;
      if (status !== exp_status(1'b1)) begin
        mismatched++;
        $display("[TB] FAIL mul_busy_%0d: got %h expected %h", k, status, exp_status(1'b1));
      end
      if (k == 1) begin
        nibble_ir = 4'h2;
        reg_en    = 9'h010;
      end else begin
        reg_en = '0;
      end
      tick();
    end
    reg_en = '0;
    model_mul(7, 9);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL mul_7_9: got %h expected %h", status, exp_status(1'b0));
    end
  endtask

  // Operand change during busy must not affect the product; an add held
  // throughout the multiply is taken only once busy has fallen.
  task automatic test_back_to_back();
    int a, b, nx;
    a  = $urandom_range(0, 15);
    b  = $urandom_range(0, 15);
    nx = $urandom_range(0, 15);
    load(0, a);
    load(2, b);
    issue_mul(1'b0, 1'b0);
    nibble_ir = 4'h2;
    for (int k = 0; k < W; k++) begin
      compared++;
      if (status !== exp_status(1'b1)) begin
        mismatched++;
        $display("[TB] FAIL b2b_busy_%0d: got %h expected %h", k, status, exp_status(1'b1));
      end
      if (k == 0) begin
        source_sel = 4'd8;
        pm_data    = 4'(nx);
        reg_en     = 9'h011;
      end else begin
        reg_en = 9'h010;
      end
      tick();
      if (k == 0) m_x[0] = nx;
    end
    model_mul(a, b);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL b2b_product: got %h expected %h", status, exp_status(1'b0));
    end
    tick();
    reg_en = '0;
    model_single(2, 1'b0, m_x[0], m_y[0]);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL b2b_add: got %h expected %h", status, exp_status(1'b0));
    end
  endtask

  task automatic test_index_mod();
    load(6, 10);
    load(5, 3);
    for (int n = 0; n < 8; n++) begin
      if (n >= 2 && n % 2 == 0) begin
        load(6, $urandom_range(0, IMOD - 1));
        load(5, $urandom_range(0, IMOD - 1));
      end
      i_sel  = 1'b1;
      reg_en = 9'h040;
      tick();
      reg_en = '0;
      i_sel  = 1'b0;
      m_i = (m_i + m_m) % IMOD;
      compared++;
      if (i !== 4'(m_i)) begin
        mismatched++;
        $display("[TB] FAIL index_inc_%0d: got %0d expected %0d", n, i, m_i);
      end
    end
  endtask

  task automatic test_nop();
    load(0, 2);
    load(2, 4);
    issue_single(2, 1'b0, 1'b0, 1'b0);
    load(0, 10);
    issue_single(7, 1'b1, 1'b0, 1'b0);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL nop7: got %h expected %h", status, exp_status(1'b0));
    end
    issue_single(0, 1'b1, 1'b0, 1'b0);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL nop0: got %h expected %h", status, exp_status(1'b0));
    end
    issue_single(7, 1'b0, 1'b0, 1'b0);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL not_x: got %h expected %h", status, exp_status(1'b0));
    end
    issue_single(0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL neg_x: got %h expected %h", status, exp_status(1'b0));
    end
    load(0, 0);
    issue_single(0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL neg_zero: got %h expected %h", status, exp_status(1'b0));
    end
    for (int s = 12; s < 16; s++) begin
      source_sel = 4'(s);
      #1;
      compared++;
      if (data_bus !== 4'h0) begin
        mismatched++;
        $display("[TB] FAIL bus_sel_%0d: got %h expected 0", s, data_bus);
      end
    end
  endtask

  task automatic test_bus();
    dm     = 4'($urandom_range(0, 15));
    i_pins = 4'($urandom_range(0, 15));
    source_sel = 4'd9;
    reg_en     = 9'h100;
    tick();
    reg_en = '0;
    m_o = int'(i_pins);
    compared++;
    if (o_reg !== 4'(m_o)) begin
      mismatched++;
      $display("[TB] FAIL o_reg_load: got %h expected %h", o_reg, 4'(m_o));
    end
    pm_data = 4'($urandom_range(0, 15));
    for (int s = 0; s < 16; s++) begin
      source_sel = 4'(s);
      #1;
      compared++;
      if (data_bus !== 4'(bus_model(s))) begin
        mismatched++;
        $display("[TB] FAIL bus_src_%0d: got %h expected %h", s, data_bus, 4'(bus_model(s)));
      end
    end
  endtask

  task automatic test_random();
    int op, xv, yv, waited;
    bit nop, xs, ys;
    for (int n = 0; n < 60; n++) begin
      load($urandom_range(0, 3), $urandom_range(0, 15));
      op  = $urandom_range(0, 7);
      nop = 1'($urandom_range(0, 1));
      xs  = 1'($urandom_range(0, 1));
      ys  = 1'($urandom_range(0, 1));
      if (op == 3) begin
        xv = m_x[xs];
        yv = m_y[ys];
        issue_mul(xs, ys);
        waited = 0;
        while (busy && waited < 20) begin
          tick();
          waited++;
        end
        compared++;
        if (waited != W) begin
          mismatched++;
          $display("[TB] FAIL rand_mul_latency_%0d: got %0d expected %0d", n, waited, W);
        end
        model_mul(xv, yv);
      end else begin
        issue_single(op, nop, xs, ys);
      end
      compared++;
      if (status !== exp_status(1'b0)) begin
        mismatched++;
        $display("[TB] FAIL rand_op%0d_%0d: got %h expected %h", op, n, status, exp_status(1'b0));
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    load(0, 5);
    load(2, 5);
    issue_mul(1'b0, 1'b0);
    tick();
    source_sel    = 4'd0;
    async_reset_n = 1'b0;
    #2;
    model_reset();
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL abort_status: got %h expected %h", status, exp_status(1'b0));
    end
    compared++;
    if (data_bus !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL abort_x0: got %h expected 0", data_bus);
    end
    async_reset_n = 1'b1;
    tick();
    tick();
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL abort_no_result: got %h expected %h", status, exp_status(1'b0));
    end
    load(0, 5);
    load(2, 5);
    issue_mul(1'b0, 1'b0);
    for (int k = 0; k < W; k++) tick();
    model_mul(5, 5);
    compared++;
    if (status !== exp_status(1'b0)) begin
      mismatched++;
      $display("[TB] FAIL mul_5_5: got %h expected %h", status, exp_status(1'b0));
    end
  endtask

  initial begin
    async_reset_n = 1'b0;
    source_sel    = '0;
    nibble_ir     = '0;
    pm_data       = '0;
    i_pins        = '0;
    dm            = '0;
    x_sel         = 1'b0;
    y_sel         = 1'b0;
    i_sel         = 1'b0;
    reg_en        = '0;
    model_reset();

    test_reset();
    test_add_sub();
    test_multiply();
    test_back_to_back();
    test_index_mod();
    test_nop();
    test_bus();
    test_random();
    test_reset_mid_mul();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
